// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam int          MULT_LAT_DEF = 4;
    localparam int          DIV_LAT_DEF  = 32;
    localparam logic [4:0]  REG_ZERO     = 5'd0;

    // A source operand collides with a destination only if it is actually read.
    function automatic logic src_hit(input logic used, input logic [4:0] src,
                                     input logic [4:0] dst);
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard inputs, mult/div issue, stall controls.
interface hazard_stall_ctrl_if;
    logic       dx_MemToReg;
    logic [4:0] dx_regDst;
    logic [4:0] fd_rs;
    logic [4:0] fd_rt;
    logic       fd_uses_rs;
    logic       fd_uses_rt;
    logic       md_start;
    logic       md_is_div;
    logic [4:0] md_rd;
    logic       stall_pipe;
    logic       stall_fd;
    logic       bubble_dx;
    logic       md_busy;
    logic       md_done;
    logic [4:0] md_wb_rd;

    modport master (
        output dx_MemToReg, dx_regDst, fd_rs, fd_rt, fd_uses_rs, fd_uses_rt,
               md_start, md_is_div, md_rd,
        input  stall_pipe, stall_fd, bubble_dx, md_busy, md_done, md_wb_rd
    );

    modport slave (
        input  dx_MemToReg, dx_regDst, fd_rs, fd_rt, fd_uses_rs, fd_uses_rt,
               md_start, md_is_div, md_rd,
        output stall_pipe, stall_fd, bubble_dx, md_busy, md_done, md_wb_rd
    );
endinterface

// File: rtl/hazard_stall_ctrl_md_seq.sv
// Mult/div sequencer: IDLE/BUSY/DONE FSM, latency down-counter and destination latch.
module md_seq
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       md_start,
    input  logic       md_is_div,
    input  logic [4:0] md_rd,
    output logic       md_busy,
    output logic       md_done,
    output logic [4:0] md_wb_rd
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rd_q, rd_d;
    logic             accept;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= REG_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // A start arriving while BUSY is impossible (X is frozen) and is dropped.
    always_comb begin
        accept  = reset && md_start && (state_q != BUSY);
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = md_is_div ? DIV_LOAD : MULT_LOAD;
                    rd_d    = md_rd;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy  = reset && ((state_q == BUSY) || accept);
    assign md_done  = reset && (state_q == DONE);
    assign md_wb_rd = rd_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller top: load-use detect, freeze priority, mult/div sequencing.
// Optional HAZARD_STATS_EN adds saturating stall-cycle counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 6
) (
    input  logic                clock,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stat_md_cycles,
    output logic [31:0]         stat_lu_cycles
`endif
);

    logic hz;
    logic md_busy;

    md_seq #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_seq (
        .clock     (clock),
        .reset     (reset),
        .md_start  (bus.md_start),
        .md_is_div (bus.md_is_div),
        .md_rd     (bus.md_rd),
        .md_busy   (md_busy),
        .md_done   (bus.md_done),
        .md_wb_rd  (bus.md_wb_rd)
    );

    // Register $0 is hardwired, so a load targeting it never creates a dependency.
    assign hz = reset && bus.dx_MemToReg && (bus.dx_regDst != REG_ZERO) &&
                (src_hit(bus.fd_uses_rs, bus.fd_rs, bus.dx_regDst) ||
                 src_hit(bus.fd_uses_rt, bus.fd_rt, bus.dx_regDst));

    // A mult/div freeze wins; the load-use check is redone once the pipe moves.
    assign bus.stall_pipe = md_busy;
    assign bus.md_busy    = md_busy;
    assign bus.stall_fd   = hz && !md_busy;
    assign bus.bubble_dx  = hz && !md_busy;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_md_cycles <= '0;
            stat_lu_cycles <= '0;
        end else begin
            if (bus.stall_pipe && (stat_md_cycles != 32'hFFFF_FFFF))
                stat_md_cycles <= stat_md_cycles + 32'd1;
            if (bus.bubble_dx && (stat_lu_cycles != 32'hFFFF_FFFF))
                stat_lu_cycles <= stat_lu_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: directed pins plus a randomized run against a timeline model.
module tb_hazard_stall_ctrl;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    hazard_stall_ctrl_if bus ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stat_md_cycles, stat_lu_cycles;
`endif

    hazard_stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef HAZARD_STATS_EN
        ,
        .stat_md_cycles (stat_md_cycles),
        .stat_lu_cycles (stat_lu_cycles)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted op at cycle s freezes cycles s..s+LAT-1 and
    // completes (md_done) at cycle s+LAT; a start there chains a new op.
    int t = 0;
    int start_t = -1;
    int end_t = -1;
    logic [4:0] rd_m = 5'd0;
    int md_cnt_m = 0;
    int lu_cnt_m = 0;

    always @(negedge clock) begin
        logic in_seq, done, accept, stall, hz, lu;
        in_seq = (end_t >= 0) && (t > start_t) && (t < end_t);
        done   = reset && (end_t >= 0) && (t == end_t);
        accept = reset && bus.md_start && !in_seq;
        stall  = reset && (in_seq || accept);
        hz = bus.dx_MemToReg && (bus.dx_regDst != 5'd0) &&
             ((bus.fd_uses_rs && bus.fd_rs == bus.dx_regDst) ||
              (bus.fd_uses_rt && bus.fd_rt == bus.dx_regDst));
        lu = reset && hz && !stall;

        check("stall_pipe", 32'(bus.stall_pipe), 32'(stall));
        check("md_busy",    32'(bus.md_busy),    32'(stall));
        check("md_done",    32'(bus.md_done),    32'(done));
        check("stall_fd",   32'(bus.stall_fd),   32'(lu));
        check("bubble_dx",  32'(bus.bubble_dx),  32'(lu));
        check("md_wb_rd",   32'(bus.md_wb_rd),   32'(rd_m));
`ifdef HAZARD_STATS_EN
        check("stat_md", stat_md_cycles, 32'(md_cnt_m));
        check("stat_lu", stat_lu_cycles, 32'(lu_cnt_m));
`endif
        if (!reset) begin
            end_t = -1; start_t = -1; rd_m = 5'd0;
            md_cnt_m = 0; lu_cnt_m = 0;
        end else begin
            if (stall) md_cnt_m++;
            if (lu)    lu_cnt_m++;
            if (accept) begin
                start_t = t;
                end_t   = t + (bus.md_is_div ? DIV_LAT : MULT_LAT);
                rd_m    = bus.md_rd;
            end else if (done) begin
                end_t = -1;
            end
        end
        t++;
    end

    task automatic clear_in();
        bus.dx_MemToReg = 0; bus.dx_regDst = 0; bus.fd_rs = 0; bus.fd_rt = 0;
        bus.fd_uses_rs = 0; bus.fd_uses_rt = 0;
        bus.md_start = 0; bus.md_is_div = 0; bus.md_rd = 0;
    endtask

    task automatic next_cycle();
        @(posedge clock); #1;
    endtask

    task automatic settle();
        @(negedge clock); #1;
    endtask

    task automatic set_lu(input logic [4:0] dst, input logic [4:0] rs);
        bus.dx_MemToReg = 1; bus.dx_regDst = dst; bus.fd_rs = rs; bus.fd_uses_rs = 1;
    endtask

    initial begin
        clear_in();
        reset = 0;
        // Reset held with a pending start: everything must stay quiet.
        bus.md_start = 1; bus.md_rd = 5'd11;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); settle();
            check("rst_stall", 32'(bus.stall_pipe), 32'd0);
            check("rst_busy",  32'(bus.md_busy),    32'd0);
        end
        next_cycle(); reset = 1; clear_in(); settle();
        check("post_rst_busy", 32'(bus.md_busy), 32'd0);
        check("post_rst_rd",   32'(bus.md_wb_rd), 32'd0);

        // Load-use on $5, then the same with $0.
        next_cycle(); set_lu(5'd5, 5'd5); settle();
        check("lu_fd",    32'(bus.stall_fd),   32'd1);
        check("lu_bub",   32'(bus.bubble_dx),  32'd1);
        check("lu_stall", 32'(bus.stall_pipe), 32'd0);
        next_cycle(); clear_in(); settle();
        check("lu_gone", 32'(bus.stall_fd), 32'd0);
        next_cycle(); set_lu(5'd0, 5'd0); settle();
        check("lu_r0", 32'(bus.bubble_dx), 32'd0);

        // Mult rd=7: freeze cycles 0..3, done on 4, idle on 5.
        next_cycle(); clear_in(); bus.md_start = 1; bus.md_rd = 5'd7; settle();
        check("mul_c0", 32'(bus.stall_pipe), 32'd1);
        next_cycle(); clear_in();
        for (int c = 1; c < 4; c++) begin
            settle(); check("mul_frz", 32'(bus.stall_pipe), 32'd1); next_cycle();
        end
        settle();
        check("mul_done", 32'(bus.md_done),    32'd1);
        check("mul_rd",   32'(bus.md_wb_rd),   32'd7);
        check("mul_run",  32'(bus.stall_pipe), 32'd0);
        next_cycle(); settle();
        check("mul_idle", 32'(bus.md_done), 32'd0);

        // Div rd=9 with a load-use held during the freeze, mult rd=3 chained on done.
        next_cycle(); bus.md_start = 1; bus.md_is_div = 1; bus.md_rd = 5'd9; settle();
        for (int c = 1; c < DIV_LAT; c++) begin
            next_cycle(); clear_in(); set_lu(5'd4, 5'd4); settle();
            if (c == 10) check("pri_bub", 32'(bus.bubble_dx), 32'd0);
        end
        next_cycle(); bus.md_start = 1; bus.md_is_div = 0; bus.md_rd = 5'd3; settle();
        check("b2b_done",  32'(bus.md_done),    32'd1);
        check("b2b_rd",    32'(bus.md_wb_rd),   32'd9);
        check("b2b_stall", 32'(bus.stall_pipe), 32'd1);
        check("b2b_bub",   32'(bus.bubble_dx),  32'd0);
        for (int c = 1; c < MULT_LAT; c++) begin
            next_cycle(); bus.md_start = 0; settle();
        end
        next_cycle(); settle();
        check("b2b_done2", 32'(bus.md_done),   32'd1);
        check("b2b_rd2",   32'(bus.md_wb_rd),  32'd3);
        check("pri_reeval", 32'(bus.bubble_dx), 32'd1);

        // Reset at cycle 2 of a mult: op abandoned, no done pulse.
        next_cycle(); clear_in(); bus.md_start = 1; bus.md_rd = 5'd6; settle();
        next_cycle(); clear_in(); settle();
        next_cycle(); reset = 0; settle();
        next_cycle(); reset = 1;
        for (int c = 0; c < 6; c++) begin
            settle(); check("abort_done", 32'(bus.md_done), 32'd0); next_cycle();
        end

        // Randomized traffic; the negedge model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            bus.dx_MemToReg = ($urandom_range(0, 1) == 1);
            bus.dx_regDst   = 5'($urandom_range(0, 3));
            bus.fd_rs       = 5'($urandom_range(0, 3));
            bus.fd_rt       = 5'($urandom_range(0, 3));
            bus.fd_uses_rs  = ($urandom_range(0, 1) == 1);
            bus.fd_uses_rt  = ($urandom_range(0, 1) == 1);
            bus.md_start    = ($urandom_range(0, 5) == 0);
            bus.md_is_div   = ($urandom_range(0, 3) == 0);
            bus.md_rd       = 5'($urandom_range(0, 31));
            next_cycle();
        end
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
